bus_mem_responder: RTL and testbench



---
 rtl/bus_mem_responder.sv | 115 +++++++++++
 tb/tb_bus_mem_responder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/bus_mem_responder.sv
// rtl/bus_mem_responder.sv - wait-state data-bus target backed by a word-organised RAM
// Returns whole aligned words on reads, lane-masked byte/half/word writes, sticky protocol error flag.
module bus_mem_responder #(
  parameter int    ADDR_BITS   = 12,
  parameter int    WAIT_STATES = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        Nrst,
  input  logic [31:0] busaddr,
  input  logic        rd_req,
  input  logic        wr_req,
  input  logic [2:0]  data_size,
  input  logic [31:0] wr_data,
  output logic        rw_wait,
  output logic [31:0] rd_data,
  output logic        protocol_err
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic {IDLE, WAITING} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [36:0] tag_q, tag_d;
  logic        perr_q, perr_d;

  logic [31:0] mem [2**ADDR_BITS];

  logic                 req, complete, err_set, size_ok, do_write;
  logic [36:0]          cur_tag;
  logic [ADDR_BITS-1:0] widx;
  logic [3:0]           lane_en;

  assign req     = rd_req | wr_req;
  assign cur_tag = {busaddr, data_size, rd_req, wr_req};
  assign widx    = busaddr[ADDR_BITS+1:2];
  assign size_ok = (data_size == 3'b001) || (data_size == 3'b010) || (data_size == 3'b100);

  always_ff @(posedge clk or negedge Nrst) begin
    if (!Nrst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      tag_q   <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
      perr_q  <= perr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tag_d    = tag_q;
    complete = 1'b0;
    err_set  = req && ((rd_req && wr_req) || (wr_req && !rd_req && !size_ok));
    case (state_q)
      IDLE: begin
        if (req) begin
          if (WS == 4'd0) begin
            complete = 1'b1;
          end else begin
            state_d = WAITING;
            tag_d   = cur_tag;
            cnt_d   = 4'd1;
          end
        end
      end
      WAITING: begin
        if (!req) begin
          err_set = 1'b1;
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cur_tag != tag_q) begin
          // A changed request is restarted in place as if seen from IDLE.
          err_set = 1'b1;
          tag_d   = cur_tag;
          cnt_d   = 4'd1;
        end else if (cnt_q == WS) begin
          complete = 1'b1;
          state_d  = IDLE;
          cnt_d    = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    perr_d = perr_q | err_set;
  end

  always_comb begin
    rw_wait  = req & ~(complete & Nrst);
    rd_data  = (complete && Nrst && rd_req) ? mem[widx] : 32'h0;
    do_write = complete && Nrst && wr_req && !rd_req && size_ok;
    case (data_size)
      3'b001:  lane_en = 4'b0001 << busaddr[1:0];
      3'b010:  lane_en = busaddr[1] ? 4'b1100 : 4'b0011;
      default: lane_en = 4'b1111;
    endcase
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (do_write && lane_en[i]) mem[widx][8*i +: 8] <= wr_data[8*i +: 8];
    end
  end

  assign protocol_err = perr_q;

endmodule

// File: tb/tb_bus_mem_responder.sv
// tb/tb_bus_mem_responder.sv - directed self-checking bench for bus_mem_responder
// Instance a uses two wait states, instance b uses zero wait states.
module tb_bus_mem_responder;

  logic        clk = 1'b0;
  logic        Nrst;
  logic [31:0] a_addr, a_wd, a_rdat, b_addr, b_wd, b_rdat;
  logic        a_rd, a_wr, a_wait, a_perr, b_rd, b_wr, b_wait, b_perr;
  logic [2:0]  a_sz, b_sz;
  int          nvec = 0;
  int          nfail = 0;

  logic [31:0] rdat;
  int          nwait;
  logic        leak;

  always #5 clk = ~clk;

  bus_mem_responder #(.ADDR_BITS(12), .WAIT_STATES(2)) u_a (
    .clk(clk), .Nrst(Nrst), .busaddr(a_addr), .rd_req(a_rd), .wr_req(a_wr),
    .data_size(a_sz), .wr_data(a_wd), .rw_wait(a_wait), .rd_data(a_rdat), .protocol_err(a_perr)
  );

  bus_mem_responder #(.ADDR_BITS(12), .WAIT_STATES(0)) u_b (
    .clk(clk), .Nrst(Nrst), .busaddr(b_addr), .rd_req(b_rd), .wr_req(b_wr),
    .data_size(b_sz), .wr_data(b_wd), .rw_wait(b_wait), .rd_data(b_rdat), .protocol_err(b_perr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic rd, input logic wr, input logic [31:0] addr, input logic [2:0] sz,
                      input logic [31:0] wd, output logic [31:0] rd_o, output int nw, output logic lk);
    nw = 0; lk = 1'b0; rd_o = 32'h0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      a_rd = rd; a_wr = wr; a_addr = addr; a_sz = sz; a_wd = wd;
      #1;
      if (!a_wait) begin
        rd_o = a_rdat;
        return;
      end
      nw++;
      if (a_rdat !== 32'h0) lk = 1'b1;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    a_rd = 1'b0; a_wr = 1'b0;
    #1;
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    a_rd = 1'b0; a_wr = 1'b0; Nrst = 1'b0;
    @(negedge clk);
    Nrst = 1'b1;
    #1;
  endtask

  initial begin
    Nrst = 1'b0;
    a_addr = '0; a_rd = 0; a_wr = 0; a_sz = 3'b100; a_wd = '0;
    b_addr = '0; b_rd = 0; b_wr = 0; b_sz = 3'b100; b_wd = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_wait", {31'd0, a_wait}, 32'd0);
    chk("rst_rdata", a_rdat, 32'h0);
    chk("rst_perr", {31'd0, a_perr}, 32'd0);
    a_rd = 1'b1; a_addr = 32'h100;
    #1;
    chk("rst_wait_req", {31'd0, a_wait}, 32'd1);
    chk("rst_rdata_req", a_rdat, 32'h0);
    @(negedge clk);
    a_rd = 1'b0; Nrst = 1'b1;

    // zero wait states: write then read each word with no bubble
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      b_wr = 1; b_rd = 0; b_addr = 32'(i * 4); b_wd = 32'hA5000000 | 32'(i * 17);
      #1;
      chk("ws0_wr_wait", {31'd0, b_wait}, 32'd0);
      chk("ws0_wr_rdata", b_rdat, 32'h0);
      @(negedge clk);
      b_wr = 0; b_rd = 1;
      #1;
      chk("ws0_rd_wait", {31'd0, b_wait}, 32'd0);
      chk("ws0_rd_data", b_rdat, 32'hA5000000 | 32'(i * 17));
    end
    @(negedge clk);
    b_rd = 0;
    chk("ws0_perr", {31'd0, b_perr}, 32'd0);

    xfer(0, 1, 32'h100, 3'b100, 32'hDEADBEEF, rdat, nwait, leak);
    chk("wr_waits", 32'(nwait), 32'd2);
    xfer(1, 0, 32'h100, 3'b100, 32'h0, rdat, nwait, leak);
    chk("rd_waits", 32'(nwait), 32'd2);
    chk("rd_word", rdat, 32'hDEADBEEF);
    chk("rd_leak", {31'd0, leak}, 32'd0);
    idle();
    chk("rd_idle", a_rdat, 32'h0);

    xfer(0, 1, 32'h200, 3'b100, 32'h0, rdat, nwait, leak);
    xfer(0, 1, 32'h203, 3'b001, 32'h5A5A5A5A, rdat, nwait, leak);
    xfer(0, 1, 32'h200, 3'b010, 32'h12341234, rdat, nwait, leak);
    xfer(1, 0, 32'h200, 3'b100, 32'h0, rdat, nwait, leak);
    chk("lane_word", rdat, 32'h5A001234);
    xfer(1, 0, 32'h201, 3'b001, 32'h0, rdat, nwait, leak);
    chk("lane_byte_rd", rdat, 32'h5A001234);
    chk("perr_clean", {31'd0, a_perr}, 32'd0);

    xfer(0, 1, 32'h10, 3'b100, 32'hAAAAAAAA, rdat, nwait, leak);
    xfer(0, 1, 32'h14, 3'b100, 32'hBBBBBBBB, rdat, nwait, leak);
    idle();
    @(negedge clk);
    a_wr = 1; a_addr = 32'h10; a_sz = 3'b100; a_wd = 32'h77777777;
    #1;
    chk("tag_w0", {31'd0, a_wait}, 32'd1);
    @(negedge clk);
    a_addr = 32'h14;
    #1;
    chk("tag_w1", {31'd0, a_wait}, 32'd1);
    @(negedge clk);
    #1;
    chk("tag_w2", {31'd0, a_wait}, 32'd1);
    chk("tag_perr", {31'd0, a_perr}, 32'd1);
    @(negedge clk);
    #1;
    chk("tag_done", {31'd0, a_wait}, 32'd0);
    idle();
    xfer(1, 0, 32'h10, 3'b100, 32'h0, rdat, nwait, leak);
    chk("tag_old", rdat, 32'hAAAAAAAA);
    xfer(1, 0, 32'h14, 3'b100, 32'h0, rdat, nwait, leak);
    chk("tag_new", rdat, 32'h77777777);

    rst_pulse();
    chk("perr_cleared", {31'd0, a_perr}, 32'd0);
    xfer(0, 1, 32'h100, 3'b011, 32'h0, rdat, nwait, leak);
    chk("bad_size_waits", 32'(nwait), 32'd2);
    idle();
    chk("bad_size_perr", {31'd0, a_perr}, 32'd1);
    xfer(1, 0, 32'h100, 3'b100, 32'h0, rdat, nwait, leak);
    chk("bad_size_mem", rdat, 32'hDEADBEEF);

    rst_pulse();
    xfer(0, 1, 32'h40, 3'b100, 32'h11111111, rdat, nwait, leak);
    xfer(1, 1, 32'h40, 3'b100, 32'h22222222, rdat, nwait, leak);
    chk("rdwr_data", rdat, 32'h11111111);
    idle();
    chk("rdwr_perr", {31'd0, a_perr}, 32'd1);
    xfer(1, 0, 32'h40, 3'b100, 32'h0, rdat, nwait, leak);
    chk("rdwr_mem", rdat, 32'h11111111);

    rst_pulse();
    xfer(0, 1, 32'h80, 3'b100, 32'h0, rdat, nwait, leak);
    idle();
    @(negedge clk);
    a_wr = 1; a_addr = 32'h80; a_sz = 3'b100; a_wd = 32'hCAFEF00D;
    #1;
    chk("mid_w0", {31'd0, a_wait}, 32'd1);
    @(negedge clk);
    #1;
    chk("mid_w1", {31'd0, a_wait}, 32'd1);
    @(negedge clk);
    Nrst = 1'b0;
    #1;
    chk("mid_in_rst", {31'd0, a_wait}, 32'd1);
    @(negedge clk);
    Nrst = 1'b1;
    #1;
    chk("mid_rel_w0", {31'd0, a_wait}, 32'd1);
    @(negedge clk);
    #1;
    chk("mid_rel_w1", {31'd0, a_wait}, 32'd1);
    @(negedge clk);
    #1;
    chk("mid_rel_done", {31'd0, a_wait}, 32'd0);
    idle();
    xfer(1, 0, 32'h80, 3'b100, 32'h0, rdat, nwait, leak);
    chk("mid_mem", rdat, 32'hCAFEF00D);
    chk("mid_perr", {31'd0, a_perr}, 32'd0);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
